// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the AES block UART link (transmit and receive sides).
package aes_uart_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned BYTE_IDX_BITS   = $clog2(AES_BLOCK_BYTES);
  localparam int unsigned BIT_IDX_BITS    = $clog2(UART_DATA_BITS);

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;
  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Byte n of a block, counting from the most-significant end.
  function automatic uart_byte_t block_byte(input aes_block_t blk, input int unsigned n);
    aes_block_t shifted;
    shifted = blk << (UART_DATA_BITS * n);
    return shifted[AES_BLOCK_BITS-1 -: UART_DATA_BITS];
  endfunction

endpackage

// File: rtl/aes_block_uart_tx_if.sv
// Block load handshake and serial-side status for the AES block UART transmitter.
interface aes_block_uart_tx_if;
  import aes_uart_pkg::*;

  aes_block_t block_in;
  logic       block_valid;
  logic       block_ready;
  logic       uart_tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output block_in,
    output block_valid,
    input  block_ready,
    input  uart_tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  block_in,
    input  block_valid,
    output block_ready,
    output uart_tx,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// One UART 8N1 byte: baud counter, start/data/stop sequencing and the registered line.
// A start seen during the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  uart_byte_t data,
  output logic       line,
  output tx_state_e  state,
  output logic       done_c
);

  localparam int unsigned BAUD_BITS = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_BITS-1:0]    BAUD_LAST = BAUD_BITS'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_BITS-1:0] BIT_LAST  = BIT_IDX_BITS'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
  end

  logic [BAUD_BITS-1:0]    baud_q;
  logic [BIT_IDX_BITS-1:0] bit_idx_q;
  uart_byte_t              sreg_q;
  logic                    bit_end_c;

  assign bit_end_c = (baud_q == BAUD_LAST);
  assign done_c    = (state == STOP) && bit_end_c;

  // Data bits leave LSB first; sreg_q shifts right as each one is put on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      sreg_q    <= '0;
      line      <= 1'b1;
    end else begin
      baud_q <= (state == IDLE || bit_end_c) ? '0 : baud_q + BAUD_BITS'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state  <= START;
            sreg_q <= data;
            line   <= 1'b0;
          end
        end
        START: begin
          if (bit_end_c) begin
            state     <= DATA;
            bit_idx_q <= '0;
            line      <= sreg_q[0];
            sreg_q    <= sreg_q >> 1;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (bit_idx_q == BIT_LAST) begin
              state <= STOP;
              line  <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_IDX_BITS'(1);
              line      <= sreg_q[0];
              sreg_q    <= sreg_q >> 1;
            end
          end
        end
        STOP: begin
          if (bit_end_c) begin
            if (start) begin
              state  <= START;
              sreg_q <= data;
              line   <= 1'b0;
            end else begin
              state <= IDLE;
              line  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          line  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/aes_block_uart_tx.sv
// Sends one 128-bit AES block as 16 back-to-back UART 8N1 bytes, most-significant byte first.
// Holds the block shift register and byte index; the byte engine owns the line.
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input logic               clk,
  input logic               rst_n,
  aes_block_uart_tx_if.slave bus
);

  localparam logic [BYTE_IDX_BITS-1:0] BYTE_LAST = BYTE_IDX_BITS'(AES_BLOCK_BYTES - 1);

  aes_block_t               shift_q;
  logic [BYTE_IDX_BITS-1:0] byte_idx_q;
  logic                     busy_q;
  logic                     tx_done_q;

  tx_state_e  tx_state;
  logic       byte_done_c;
  logic       accept_c;
  logic       byte_start_c;
  uart_byte_t byte_data_c;

  assign bus.block_ready = (tx_state == IDLE);
  assign bus.busy        = busy_q;
  assign bus.tx_done     = tx_done_q;

  assign accept_c = bus.block_valid && bus.block_ready;

  // While busy, the next byte is offered continuously; the engine only takes it at stop-bit end.
  assign byte_start_c = accept_c || (busy_q && (byte_idx_q != BYTE_LAST));
  assign byte_data_c  = busy_q ? block_byte(shift_q, 1) : block_byte(bus.block_in, 0);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (byte_start_c),
    .data   (byte_data_c),
    .line   (bus.uart_tx),
    .state  (tx_state),
    .done_c (byte_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (accept_c) begin
        shift_q    <= bus.block_in;
        byte_idx_q <= '0;
        busy_q     <= 1'b1;
      end else if (byte_done_c) begin
        if (byte_idx_q == BYTE_LAST) begin
          busy_q     <= 1'b0;
          tx_done_q  <= 1'b1;
          byte_idx_q <= '0;
        end else begin
          shift_q    <= shift_q << UART_DATA_BITS;
          byte_idx_q <= byte_idx_q + BYTE_IDX_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Scoreboard bench for aes_block_uart_tx: expected bytes queued at issue, a UART
// decoder pops and compares; a control monitor checks tx_done timing.
module tb_aes_block_uart_tx;
  import aes_uart_pkg::*;

  localparam int unsigned CPB          = 4;
  localparam int unsigned BYTE_CYCLES  = 10 * CPB;
  localparam int unsigned FRAME_CYCLES = 16 * BYTE_CYCLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aes_block_uart_tx_if bus();

  aes_block_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp      = 0;
  int          n_bad      = 0;
  int          n_done     = 0;
  int          n_exp_done = 0;
  int unsigned cyc        = 0;
  int unsigned acc_cyc    = 0;
  logic [7:0]  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int n);
    logic [127:0] s;
    s = blk << (8 * n);
    return s[127:120];
  endfunction

  // Expected line level t cycles after the acceptance edge.
  function automatic logic exp_level(input logic [127:0] blk, input int t);
    int n, pos;
    logic [7:0] bv;
    n   = t / 40;
    pos = (t % 40) / 4;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    bv = exp_byte(blk, n);
    return ((bv >> (pos - 1)) & 8'd1) != 8'd0;
  endfunction

  task automatic push_block(input logic [127:0] blk);
    for (int n = 0; n < 16; n++) exp_q.push_back(exp_byte(blk, n));
  endtask

  // Decoder: start detected half a cycle in, each later bit sampled near its middle.
  initial begin : byte_mon
    logic [7:0] b;
    logic       stop_b;
    bit         aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.uart_tx === 1'b0) begin
        aborted = 1'b0;
        b       = '0;
        stop_b  = 1'b0;
        for (int k = 0; k < 9; k++) begin
          repeat ((k == 0) ? 5 : 4) begin
            @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
          end
          if (k < 8) b = {bus.uart_tx, b[7:1]};
          else stop_b = bus.uart_tx;
        end
        if (!aborted) begin
          chk1("stop_bit", stop_b, 1'b1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h, required none", b);
          end else begin
            e = exp_q.pop_front();
            chkw("byte", 128'(b), 128'(e));
          end
        end
      end
    end
  end

  initial begin : ctl_mon
    logic busy_prev;
    logic done_prev;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1 && busy_prev !== 1'b1) acc_cyc = cyc;
      if (bus.tx_done === 1'b1) begin
        n_done++;
        chkw("done_latency", 128'(cyc - acc_cyc), 128'(FRAME_CYCLES));
        chk1("done_single_cycle", done_prev, 1'b0);
        chk1("busy_at_done", bus.busy, 1'b0);
        chk1("ready_at_done", bus.block_ready, 1'b1);
        chk1("line_at_done", bus.uart_tx, 1'b1);
      end
      busy_prev = bus.busy;
      done_prev = bus.tx_done;
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.block_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bus.block_ready !== 1'b1) chk1("ready_timeout", bus.block_ready, 1'b1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (bus.tx_done !== 1'b1 && t < int'(FRAME_CYCLES) + 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.tx_done !== 1'b1) chk1("done_timeout", bus.tx_done, 1'b1);
  endtask

  // Returns at the first negedge after the acceptance edge.
  task automatic send(input logic [127:0] blk);
    wait_ready();
    bus.block_in    = blk;
    bus.block_valid = 1'b1;
    push_block(blk);
    @(negedge clk);
    bus.block_valid = 1'b0;
    bus.block_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk1("busy_after_accept", bus.busy, 1'b1);
    chk1("ready_after_accept", bus.block_ready, 1'b0);
    chk1("line_low_at_accept", bus.uart_tx, 1'b0);
  endtask

  task automatic check_wave(input logic [127:0] blk);
    int errs;
    errs = 0;
    for (int t = 0; t < int'(FRAME_CYCLES); t++) begin
      if (t > 0) @(negedge clk);
      if (bus.uart_tx !== exp_level(blk, t)) errs++;
    end
    chkw("line_waveform_errors", 128'(errs), 128'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk1({tag, "_uart_tx"}, bus.uart_tx, 1'b1);
    chk1({tag, "_ready"}, bus.block_ready, 1'b1);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_tx_done"}, bus.tx_done, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int busy_low;
    int gap;
    bus.block_in    = '0;
    bus.block_valid = 1'b0;

    // Reset state, then reset asserted in the middle of a data bit.
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(128'hA5A5_5A5A_0123_4567_89AB_CDEF_1357_9BDF);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_values("midbit_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Ascending byte block with full line waveform check.
    send(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    check_wave(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    wait_done();
    n_exp_done++;
    repeat (3) @(negedge clk);

    // Alternating pattern: every bit exactly CPB cycles.
    send({16{8'h55}});
    check_wave({16{8'h55}});
    wait_done();
    n_exp_done++;
    repeat (3) @(negedge clk);

    // A second block offered while busy must be ignored.
    send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    repeat (20) @(negedge clk);
    bus.block_in    = {4{32'hDEAD_BEEF}};
    bus.block_valid = 1'b1;
    busy_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_low++;
    end
    bus.block_valid = 1'b0;
    chkw("busy_low_while_offered", 128'(busy_low), 128'd0);
    wait_done();
    n_exp_done++;
    repeat (2) @(negedge clk);
    chk1("not_reaccepted_busy", bus.busy, 1'b0);
    chkw("queue_after_ignored", 128'(exp_q.size()), 128'd0);

    // Back-to-back blocks with block_valid held high.
    wait_ready();
    bus.block_in    = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
    bus.block_valid = 1'b1;
    push_block(128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F);
    @(negedge clk);
    chk1("b2b_first_busy", bus.busy, 1'b1);
    bus.block_in = 128'h8001_4002_2004_1008_0810_0420_0240_0180;
    push_block(128'h8001_4002_2004_1008_0810_0420_0240_0180);
    wait_done();
    gap = 0;
    while (bus.busy !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    bus.block_valid = 1'b0;
    chkw("b2b_idle_gap_cycles", 128'(gap), 128'd1);
    chk1("b2b_second_start_low", bus.uart_tx, 1'b0);
    wait_done();
    n_exp_done += 2;
    repeat (3) @(negedge clk);

    // Reset during byte 5 abandons the rest; the next block starts at byte 0.
    send(128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
    repeat (220) @(negedge clk);
    chkw("bytes_pending_before_abort", 128'(exp_q.size()), 128'd11);
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_values("abort_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    send(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    wait_done();
    n_exp_done++;

    repeat (5) @(negedge clk);
    chkw("done_pulse_count", 128'(n_done), 128'(n_exp_done));
    chkw("leftover_expected_bytes", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
